collision_scheduler: RTL

Time-multiplexes one player-vs-obstacle collision comparator across all obstacle slots of the game's obstacle table. On each `frame_start` it snapshots the player position, then walks slots 0..NOBST-1, fetching each slot and testing it. It counts each obstacle at most once while that obstacle stays resident, and reports per-hit and per-frame results to the game FSM and score logic. It sits between the vsync frame tick, the obstacle table RAM and the score/lives counters.

---
 rtl/collision_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/collision_scheduler.sv
// Time-multiplexed player-vs-obstacle collision scanner over an NOBST-slot obstacle table.
// Optional horizontal tolerance check enabled by defining COLLISION_HCHECK_EN.
module collision_scheduler #(
  parameter  int HWIDTH      = 12,
  parameter  int VWIDTH      = 12,
  parameter  int LWIDTH      = 2,
  parameter  int COUNT_WIDTH = 32,
  parameter  int NOBST       = 8,
  parameter  int VTOL        = 5,
  parameter  int HTOL        = 16,
  localparam int IWIDTH      = $clog2(NOBST)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     clear,
  input  logic signed [HWIDTH-1:0] player_hoffset,
  input  logic signed [VWIDTH-1:0] player_voffset,
  input  logic        [LWIDTH-1:0] player_lane,
  output logic        [IWIDTH-1:0] obst_idx,
  input  logic                     obst_valid,
  input  logic signed [HWIDTH-1:0] obst_hoffset,
  input  logic signed [VWIDTH-1:0] obst_voffset,
  input  logic        [LWIDTH-1:0] obst_lane,
  output logic                     busy,
  output logic                     done,
  output logic                     hit,
  output logic        [IWIDTH-1:0] hit_slot,
  output logic                     frame_hit,
  output logic                     overrun,
  output logic   [COUNT_WIDTH-1:0] count
);

  typedef enum logic [1:0] {IDLE, FETCH, CHECK, DONE} state_t;

  localparam logic [VWIDTH:0]   VTOL_L    = (VWIDTH+1)'(VTOL);
  localparam logic [IWIDTH-1:0] LAST_SLOT = IWIDTH'(NOBST-1);

  state_t                    state;
  logic [IWIDTH-1:0]         slot;
  logic [NOBST-1:0]          armed;
  logic                      scan_hit;
  logic                      match;
  logic                      new_hit;
  logic signed [VWIDTH-1:0]  snap_v;
  logic        [LWIDTH-1:0]  snap_lane;

  // One extra bit keeps the difference exact even between opposite extremes.
  function automatic logic [VWIDTH:0] abs_diff_v(input logic signed [VWIDTH-1:0] a,
                                                 input logic signed [VWIDTH-1:0] b);
    logic signed [VWIDTH:0] d;
    d = (VWIDTH+1)'(a) - (VWIDTH+1)'(b);
    return d[VWIDTH] ? (VWIDTH+1)'(-d) : (VWIDTH+1)'(d);
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (&c) ? c : c + COUNT_WIDTH'(1);
  endfunction

`ifdef COLLISION_HCHECK_EN
  localparam logic [HWIDTH:0] HTOL_L = (HWIDTH+1)'(HTOL);

  logic signed [HWIDTH-1:0] snap_h;

  function automatic logic [HWIDTH:0] abs_diff_h(input logic signed [HWIDTH-1:0] a,
                                                 input logic signed [HWIDTH-1:0] b);
    logic signed [HWIDTH:0] d;
    d = (HWIDTH+1)'(a) - (HWIDTH+1)'(b);
    return d[HWIDTH] ? (HWIDTH+1)'(-d) : (HWIDTH+1)'(d);
  endfunction

  always_ff @(posedge clk) begin
    if (state == IDLE && frame_start) snap_h <= player_hoffset;
  end

  always_comb begin
    match = obst_valid && (obst_lane == snap_lane) &&
            (abs_diff_v(obst_voffset, snap_v) <= VTOL_L) &&
            (abs_diff_h(obst_hoffset, snap_h) <= HTOL_L);
  end
`else
  logic        unused_h;
  logic [31:0] unused_htol;
  assign unused_h    = ^{player_hoffset, obst_hoffset};
  assign unused_htol = 32'(HTOL);

  always_comb begin
    match = obst_valid && (obst_lane == snap_lane) &&
            (abs_diff_v(obst_voffset, snap_v) <= VTOL_L);
  end
`endif

  assign new_hit  = match && armed[slot];
  assign obst_idx = slot;

  // Player snapshot is pure data and is only ever consumed during a scan.
  always_ff @(posedge clk) begin
    if (state == IDLE && frame_start) begin
      snap_v    <= player_voffset;
      snap_lane <= player_lane;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      slot      <= '0;
      armed     <= '1;
      scan_hit  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      hit_slot  <= '0;
      frame_hit <= 1'b0;
      overrun   <= 1'b0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      hit  <= 1'b0;
      if (frame_start && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start) begin
            slot     <= '0;
            busy     <= 1'b1;
            scan_hit <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: state <= CHECK;
        CHECK: begin
          if (new_hit) begin
            hit         <= 1'b1;
            hit_slot    <= slot;
            scan_hit    <= 1'b1;
            count       <= sat_inc(count);
            armed[slot] <= 1'b0;
          end else if (!obst_valid) begin
            armed[slot] <= 1'b1;
          end
          if (slot == LAST_SLOT) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            frame_hit <= scan_hit | new_hit;
            state     <= DONE;
          end else begin
            slot  <= slot + IWIDTH'(1);
            state <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Placed last so a coincident counted hit loses its increment and disarm.
      if (clear) begin
        count <= '0;
        armed <= '1;
      end
    end
  end

endmodule
